// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control FSM
// Purpose: state encoding, supported opcodes and datapath select encodings used
//          by multicycle_ctrl and anything that decodes its select outputs.
// Ports:   none (package).
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I core
// Purpose: sequences the shared memory port, ALU and register file through
//          FETCH..WRITEBACK for R-type, I-type ALU, lw and sw; stalls on
//          mem_ready, counts retired instructions, halts on unsupported opcodes.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   opcode[6:0]         IR[6:0], looked at only in DECODE and MEMADR
//   mem_ready           memory access completes on a cycle with it high
//   pc_write, ir_write  PC / IR+oldPC write enables
//   adr_src             memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write memory requests
//   reg_write           register file write enable
//   alu_src_a/b, alu_op, result_src  datapath selects (see riscv_ctrl_pkg)
//   halted              high while stopped on an illegal opcode
//   instr_retired       retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             halted,
  output logic [CNT_W-1:0] instr_retired
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   instr_retired_q, instr_retired_d;
  logic               retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_FETCH;
      instr_retired_q <= '0;
    end else begin
      state_q         <= state_d;
      instr_retired_q <= instr_retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_LW, OP_SW: state_d = S_MEMADR;
          // Unsupported opcodes either stop the core or are dropped unretired.
          default:      state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its last state; a store's
  // last state is MEMWR, which it leaves only once the write is accepted.
  always_comb begin
    retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
             ((state_q == S_MEMWR) && mem_ready);
    instr_retired_d = instr_retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  assign instr_retired = instr_retired_q;

  // Moore decode from the state register only (FETCH's write enables follow
  // mem_ready so PC/IR update on the cycle the fetch completes).
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALU;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_ILLEGAL: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LW_OP = 7'b0000011;
  localparam logic [6:0] SW_OP = 7'b0100011;
  localparam logic [6:0] BAD_OP = 7'b1111111;

  typedef enum int {PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMRD, PH_MEMWB,
                    PH_MEMWR, PH_EXECR, PH_EXECI, PH_ALUWB, PH_HALT} ph_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic mem_ready = 1'b0;

  logic pc_write_a, ir_write_a, adr_src_a, mem_read_a, mem_write_a, reg_write_a, halted_a;
  logic [1:0] src_a_a, src_b_a, alu_op_a, result_src_a;
  logic [3:0] cnt_a;
  logic pc_write_b, ir_write_b, adr_src_b, mem_read_b, mem_write_b, reg_write_b, halted_b;
  logic [1:0] src_a_b, src_b_b, alu_op_b, result_src_b;
  logic [31:0] cnt_b;

  multicycle_ctrl #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .ir_write(ir_write_a), .adr_src(adr_src_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .reg_write(reg_write_a),
    .alu_src_a(src_a_a), .alu_src_b(src_b_a), .alu_op(alu_op_a),
    .result_src(result_src_a), .halted(halted_a), .instr_retired(cnt_a));

  multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .ir_write(ir_write_b), .adr_src(adr_src_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .reg_write(reg_write_b),
    .alu_src_a(src_a_b), .alu_src_b(src_b_b), .alu_op(alu_op_b),
    .result_src(result_src_b), .halted(halted_b), .instr_retired(cnt_b));

  always #5 clk = ~clk;

  // {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, a, b, op, result_src, halted}
  wire [14:0] ctrl_a = {pc_write_a, ir_write_a, adr_src_a, mem_read_a, mem_write_a,
                        reg_write_a, src_a_a, src_b_a, alu_op_a, result_src_a, halted_a};
  wire [14:0] ctrl_b = {pc_write_b, ir_write_b, adr_src_b, mem_read_b, mem_write_b,
                        reg_write_b, src_a_b, src_b_b, alu_op_b, result_src_b, halted_b};

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_total = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word each phase of an instruction must present, straight from the
  // per-state output table of the controller description.
  function automatic logic [14:0] exp_ctrl(input ph_t p, input logic rdy);
    logic pcw, irw, adr, mr, mw, rw, hlt;
    logic [1:0] a, b, op, rs;
    {pcw, irw, adr, mr, mw, rw, hlt} = '0;
    {a, b, op, rs} = '0;
    case (p)
      PH_FETCH:  begin mr = 1; pcw = rdy; irw = rdy; b = 2'b10; rs = 2'b10; end
      PH_MEMADR: begin a = 2'b10; b = 2'b01; end
      PH_MEMRD:  begin adr = 1; mr = 1; end
      PH_MEMWB:  begin rs = 2'b01; rw = 1; end
      PH_MEMWR:  begin adr = 1; mw = 1; end
      PH_EXECR:  begin a = 2'b10; op = 2'b10; end
      PH_EXECI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      PH_ALUWB:  begin rw = 1; end
      PH_HALT:   begin hlt = 1; end
      default: ;
    endcase
    return {pcw, irw, adr, mr, mw, rw, a, b, op, rs, hlt};
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // One clock of stimulus: drive on the falling edge, sample 1 time unit later.
  // pa/pb are the phases expected from the halting and the NOP-skip instances.
  task automatic step2(input ph_t pa, input ph_t pb, input logic rdy,
                       input logic [6:0] op, input logic retires);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    #1;
    check($sformatf("ctrl_%s", pa.name()), 32'(ctrl_a), 32'(exp_ctrl(pa, rdy)));
    check($sformatf("nop_ctrl_%s", pb.name()), 32'(ctrl_b), 32'(exp_ctrl(pb, rdy)));
    check("mutex", {30'd0, mem_read_a & mem_write_a, reg_write_a & (mem_read_a | mem_write_a)}, 32'd0);
    check("cnt", 32'(cnt_a), {28'd0, exp_total[3:0]});
    check("nop_cnt", cnt_b, exp_total);
    if (retires) exp_total = exp_total + 32'd1;
  endtask

  task automatic step(input ph_t p, input logic rdy, input logic [6:0] op, input logic retires);
    step2(p, p, rdy, op, retires);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(PH_FETCH, 1'b0, junk(), 1'b0);
    step(PH_FETCH, 1'b1, junk(), 1'b0);
    step(PH_DECODE, rbit(), op, 1'b0);
    if (op == R_OP || op == I_OP) begin
      step((op == R_OP) ? PH_EXECR : PH_EXECI, rbit(), junk(), 1'b0);
      step(PH_ALUWB, rbit(), junk(), 1'b1);
    end else begin
      step(PH_MEMADR, rbit(), op, 1'b0);
      if (op == LW_OP) begin
        for (int i = 0; i < mw; i++) step(PH_MEMRD, 1'b0, junk(), 1'b0);
        step(PH_MEMRD, 1'b1, junk(), 1'b0);
        step(PH_MEMWB, rbit(), junk(), 1'b1);
      end else begin
        for (int i = 0; i < mw; i++) step(PH_MEMWR, 1'b0, junk(), 1'b0);
        step(PH_MEMWR, 1'b1, junk(), 1'b1);
      end
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_ctrl", 32'(ctrl_a), 32'(exp_ctrl(PH_FETCH, 1'b0)));
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_nop_cnt", cnt_b, 32'd0);
    exp_total = 32'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [6:0] ops [4];

  initial begin
    ops[0] = R_OP; ops[1] = I_OP; ops[2] = LW_OP; ops[3] = SW_OP;
    do_reset();

    // Directed: R-type, lw with two MEMRD wait cycles, sw with no waits.
    run_instr(R_OP, 0, 0);
    run_instr(LW_OP, 0, 2);
    run_instr(SW_OP, 0, 0);

    // Reset asserted while a store is stalled in MEMWR.
    step(PH_FETCH, 1'b1, junk(), 1'b0);
    step(PH_DECODE, rbit(), SW_OP, 1'b0);
    step(PH_MEMADR, rbit(), SW_OP, 1'b0);
    step(PH_MEMWR, 1'b0, junk(), 1'b0);
    reset = 1'b1;
    #1;
    check("rst_async_mem_write", {31'd0, mem_write_a}, 32'd0);
    check("rst_async_ctrl", 32'(ctrl_a), 32'(exp_ctrl(PH_FETCH, 1'b0)));
    check("rst_async_cnt", 32'(cnt_a), 32'd0);
    exp_total = 32'd0;
    @(negedge clk);
    reset = 1'b0;

    // Sixteen addi: 4-bit counter wraps back to zero.
    for (int i = 0; i < 16; i++) run_instr(I_OP, 0, 0);
    step(PH_FETCH, 1'b0, junk(), 1'b0);
    check("wrap_cnt", 32'(cnt_a), 32'd0);
    check("wrap_nop_cnt", cnt_b, 32'd16);

    // Random instruction mix with random wait states.
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 2), $urandom_range(0, 2));

    // Illegal opcode: halting instance sticks, NOP instance refetches.
    step(PH_FETCH, 1'b1, junk(), 1'b0);
    step(PH_DECODE, rbit(), BAD_OP, 1'b0);
    for (int i = 0; i < 6; i++) step2(PH_HALT, PH_FETCH, 1'b0, junk(), 1'b0);
    do_reset();
    check("halt_cleared", {31'd0, halted_a}, 32'd0);
    run_instr(R_OP, 1, 0);
    step(PH_FETCH, 1'b0, junk(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
